// File: rtl/slow_llr_calc_if.sv
// Bus bundle between the slow LLR calculator, its PHY reader (inputs) and the LLR packer (outputs).
interface slow_llr_calc_if #(parameter int LLR_W = 8);
  logic                 i_user_start;
  logic [15:0]          i_cur_user_re_amounts;
  logic                 i_data_strobe;
  logic [15:0]          i_re0_data_i;
  logic [15:0]          i_re0_data_q;
  logic [15:0]          i_re1_data_i;
  logic [15:0]          i_re1_data_q;
  logic [15:0]          i_noise_data;
  logic                 i_llr_ready;
  logic                 o_llr_valid;
  logic [4*LLR_W-1:0]   o_llr_data;
  logic                 o_llr_re1_vld;
  logic                 o_llr_last;
  logic                 o_busy;
  logic                 o_fifo_ovf;
  logic                 o_err_extra;
  logic [15:0]          o_sat_cnt;

  modport slave (
    input  i_user_start, i_cur_user_re_amounts, i_data_strobe,
           i_re0_data_i, i_re0_data_q, i_re1_data_i, i_re1_data_q,
           i_noise_data, i_llr_ready,
    output o_llr_valid, o_llr_data, o_llr_re1_vld, o_llr_last,
           o_busy, o_fifo_ovf, o_err_extra, o_sat_cnt
  );

  modport master (
    output i_user_start, i_cur_user_re_amounts, i_data_strobe,
           i_re0_data_i, i_re0_data_q, i_re1_data_i, i_re1_data_q,
           i_noise_data, i_llr_ready,
    input  o_llr_valid, o_llr_data, o_llr_re1_vld, o_llr_last,
           o_busy, o_fifo_ovf, o_err_extra, o_sat_cnt
  );
endinterface

// File: rtl/slow_llr_calc.sv
// Slow LLR calculator: 4 scaled/rounded/saturated soft bits per RE pair, per-user RE tracking, output FIFO.
// Define SLOW_LLR_SAT_CNT_EN to build the per-user saturation counter (o_sat_cnt); otherwise it is tied to 0.

// One field: registered product, then combinational round + saturate.
module slow_llr_lane #(
  parameter int SHIFT = 10,
  parameter int LLR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [15:0]       sample,
  input  logic [15:0]       noise,
`ifdef SLOW_LLR_SAT_CNT_EN
  output logic              sat,
`endif
  output logic [LLR_W-1:0]  llr
);
  localparam logic signed [33:0] RND  = 34'sd1 <<< (SHIFT - 1);
  localparam logic signed [33:0] MAXV = (34'sd1 <<< (LLR_W - 1)) - 34'sd1;
  localparam logic signed [33:0] MINV = -(34'sd1 <<< (LLR_W - 1));

  logic signed [32:0] prod_q;
  logic signed [33:0] rnd, shr;
  logic               hi, lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     prod_q <= '0;
    else if (en) prod_q <= 33'($signed(sample)) * 33'($signed({1'b0, noise}));
  end

  always_comb begin
    rnd = {prod_q[32], prod_q} + RND;
    shr = rnd >>> SHIFT;
    hi  = shr > MAXV;
    lo  = shr < MINV;
    llr = hi ? MAXV[LLR_W-1:0] : lo ? MINV[LLR_W-1:0] : shr[LLR_W-1:0];
  end

`ifdef SLOW_LLR_SAT_CNT_EN
  assign sat = hi | lo;
`endif
endmodule

module slow_llr_calc #(
  parameter int LLR_W      = 8,
  parameter int SHIFT      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           i_core_clk,
  input  logic           i_rx_rst,
  slow_llr_calc_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic                              last;
    logic                              re1_vld;
    logic [NUM_LANES-1:0][LLR_W-1:0]   llr;
  } entry_t;

  state_t       state;
  logic [15:0]  amt_q;
  logic [16:0]  re_cnt;
  logic [15:0]  amt_eff;
  logic [16:0]  cnt_nxt;
  logic         eff_run, acc, last_in, pad_in;

  // A start in the same cycle as a strobe makes the strobe the first pair of the new user.
  always_comb begin
    amt_eff = bus.i_user_start ? bus.i_cur_user_re_amounts : amt_q;
    eff_run = bus.i_user_start ? (bus.i_cur_user_re_amounts != 16'd0) : (state == RUN);
    cnt_nxt = (bus.i_user_start ? 17'd0 : re_cnt) + 17'd2;
    acc     = bus.i_data_strobe && eff_run;
    last_in = cnt_nxt >= {1'b0, amt_eff};
    pad_in  = cnt_nxt >  {1'b0, amt_eff};
  end

  // Stage 1: products live in the lanes; tags travel alongside.
  logic s1_vld, s1_last, s1_pad;

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_pad  <= 1'b0;
    end else begin
      s1_vld  <= acc;
      s1_last <= acc && last_in;
      s1_pad  <= acc && pad_in;
    end
  end

  logic [NUM_LANES-1:0][15:0]      smp;
  logic [NUM_LANES-1:0][LLR_W-1:0] lane_llr;
`ifdef SLOW_LLR_SAT_CNT_EN
  logic [NUM_LANES-1:0]            lane_sat;
`endif

  assign smp = {bus.i_re1_data_q, bus.i_re1_data_i, bus.i_re0_data_q, bus.i_re0_data_i};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    slow_llr_lane #(.SHIFT(SHIFT), .LLR_W(LLR_W)) u_lane (
      .clk    (i_core_clk),
      .rst    (i_rx_rst),
      .en     (acc),
      .sample (smp[g]),
      .noise  (bus.i_noise_data),
`ifdef SLOW_LLR_SAT_CNT_EN
      .sat    (lane_sat[g]),
`endif
      .llr    (lane_llr[g])
    );
  end

  // Stage 2: rounded/saturated lanes; padding re1 is zeroed.
  entry_t wr_ent;

  always_comb begin
    wr_ent.last    = s1_last;
    wr_ent.re1_vld = !s1_pad;
    wr_ent.llr     = lane_llr;
    if (s1_pad) wr_ent.llr[3:2] = '0;
  end

  // Output FIFO
  entry_t      mem [FIFO_DEPTH];
  entry_t      head;
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, rd_en, wr_ok, drop;

  always_comb begin
    empty = wr_ptr == rd_ptr;
    full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    rd_en = !empty && bus.i_llr_ready;
    wr_ok = s1_vld && (!full || rd_en);
    drop  = s1_vld && full && !rd_en;
    head  = mem[rd_ptr[PW-1:0]];
  end

  always_ff @(posedge i_core_clk) begin
    if (wr_ok) mem[wr_ptr[PW-1:0]] <= wr_ent;
  end

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PONE;
      if (rd_en) rd_ptr <= rd_ptr + PONE;
    end
  end

  // Tagged-last entries still in flight; DONE waits for them to leave (read or dropped).
  logic [3:0] pend, pend_nxt;

  assign pend_nxt = pend + {3'b0, acc && last_in}
                         - {3'b0, (rd_en && head.last) || (drop && s1_last)};

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) pend <= '0;
    else          pend <= pend_nxt;
  end

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      state  <= IDLE;
      amt_q  <= '0;
      re_cnt <= '0;
    end else if (bus.i_user_start) begin
      amt_q  <= bus.i_cur_user_re_amounts;
      re_cnt <= acc ? 17'd2 : 17'd0;
      state  <= (!eff_run || (acc && last_in)) ? DONE : RUN;
    end else begin
      case (state)
        RUN: if (acc) begin
          re_cnt <= cnt_nxt;
          if (last_in) state <= DONE;
        end
        DONE: if (pend_nxt == 4'd0) state <= IDLE;
        default: ;
      endcase
    end
  end

  logic ovf_q, err_q;

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      if (bus.i_data_strobe && !eff_run) err_q <= 1'b1;
    end
  end

`ifdef SLOW_LLR_SAT_CNT_EN
  logic [15:0]          sat_cnt;
  logic [NUM_LANES-1:0] sat_m;
  logic [2:0]           sat_add;
  logic [16:0]          sat_sum;

  always_comb begin
    sat_m   = s1_pad ? {2'b00, lane_sat[1:0]} : lane_sat;
    sat_add = '0;
    for (int l = 0; l < NUM_LANES; l++) sat_add = sat_add + {2'b00, sat_m[l]};
    sat_sum = {1'b0, sat_cnt} + {14'd0, sat_add};
  end

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst)              sat_cnt <= '0;
    else if (bus.i_user_start) sat_cnt <= '0;
    else if (wr_ok)            sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  assign bus.o_sat_cnt = sat_cnt;
`else
  assign bus.o_sat_cnt = '0;
`endif

  // Head fields are gated so a stale or uninitialised slot never shows while empty.
  assign bus.o_llr_valid   = !empty;
  assign bus.o_llr_data    = empty ? '0 : head.llr;
  assign bus.o_llr_re1_vld = !empty && head.re1_vld;
  assign bus.o_llr_last    = !empty && head.last;
  assign bus.o_busy        = (state == RUN) || s1_vld || !empty;
  assign bus.o_fifo_ovf    = ovf_q;
  assign bus.o_err_extra   = err_q;
endmodule

// File: tb/tb_slow_llr_calc.sv
// Directed bench for slow_llr_calc (LLR_W=8, SHIFT=2, FIFO_DEPTH=4); works with or without SLOW_LLR_SAT_CNT_EN.
module tb_slow_llr_calc;
  logic tb_sclk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 tb_sclk = ~tb_sclk;

  slow_llr_calc_if #(.LLR_W(8)) bus ();

  slow_llr_calc #(.LLR_W(8), .SHIFT(2), .FIFO_DEPTH(4)) dut (
    .i_core_clk (tb_sclk),
    .i_rx_rst   (rst),
    .bus        (bus)
  );

`ifdef SLOW_LLR_SAT_CNT_EN
  localparam logic [15:0] SAT_EXP = 16'd2;
`else
  localparam logic [15:0] SAT_EXP = 16'd0;
`endif

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic start_user(input int amt);
    bus.i_user_start          = 1'b1;
    bus.i_cur_user_re_amounts = 16'(amt);
    @(negedge tb_sclk);
    bus.i_user_start          = 1'b0;
  endtask

  task automatic strobe(input int a, input int b, input int c, input int d, input int n, input bit st);
    bus.i_data_strobe = 1'b1;
    bus.i_user_start  = st;
    bus.i_re0_data_i  = 16'(a);
    bus.i_re0_data_q  = 16'(b);
    bus.i_re1_data_i  = 16'(c);
    bus.i_re1_data_q  = 16'(d);
    bus.i_noise_data  = 16'(n);
    @(negedge tb_sclk);
    bus.i_data_strobe = 1'b0;
    bus.i_user_start  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_user_start = 0; bus.i_cur_user_re_amounts = 0; bus.i_data_strobe = 0;
    bus.i_re0_data_i = 0; bus.i_re0_data_q = 0; bus.i_re1_data_i = 0; bus.i_re1_data_q = 0;
    bus.i_noise_data = 0; bus.i_llr_ready = 0;
    @(negedge tb_sclk);
    total++; if ({bus.o_llr_valid, bus.o_llr_last, bus.o_llr_re1_vld, bus.o_busy, bus.o_fifo_ovf, bus.o_err_extra} !== 6'b0) begin
      bad++; $display("FAIL rst_flags got=%b want=000000", {bus.o_llr_valid, bus.o_llr_last, bus.o_llr_re1_vld, bus.o_busy, bus.o_fifo_ovf, bus.o_err_extra}); end
    total++; if (bus.o_llr_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.o_llr_data); end
    total++; if (bus.o_sat_cnt !== 16'h0) begin bad++; $display("FAIL rst_sat got=%h want=0", bus.o_sat_cnt); end
    rst = 1'b0;
    @(negedge tb_sclk);
  endtask

  task automatic test_basic;
    bus.i_llr_ready = 1'b0;
    start_user(4);
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_run got=%b want=1", bus.o_busy); end
    strobe(12, 17, 34, 51, 6, 0);
    total++; if (bus.o_llr_valid !== 1'b0) begin bad++; $display("FAIL basic_latency1 got=%b want=0", bus.o_llr_valid); end
    strobe(-10, -3, 5, 0, 6, 0);
    total++; if (bus.o_llr_valid !== 1'b1) begin bad++; $display("FAIL basic_latency2 got=%b want=1", bus.o_llr_valid); end
    total++; if (bus.o_llr_data !== pk(18, 26, 51, 77)) begin bad++; $display("FAIL basic_data0 got=%h want=%h", bus.o_llr_data, pk(18, 26, 51, 77)); end
    total++; if ({bus.o_llr_last, bus.o_llr_re1_vld} !== 2'b01) begin bad++; $display("FAIL basic_tags0 got=%b want=01", {bus.o_llr_last, bus.o_llr_re1_vld}); end
    @(negedge tb_sclk);
    bus.i_llr_ready = 1'b1;
    @(negedge tb_sclk);
    total++; if (bus.o_llr_data !== pk(-15, -4, 8, 0)) begin bad++; $display("FAIL basic_data1 got=%h want=%h", bus.o_llr_data, pk(-15, -4, 8, 0)); end
    total++; if ({bus.o_llr_last, bus.o_llr_re1_vld} !== 2'b11) begin bad++; $display("FAIL basic_tags1 got=%b want=11", {bus.o_llr_last, bus.o_llr_re1_vld}); end
    @(negedge tb_sclk);
    total++; if ({bus.o_llr_valid, bus.o_busy, bus.o_err_extra} !== 3'b000) begin
      bad++; $display("FAIL basic_idle got=%b want=000", {bus.o_llr_valid, bus.o_busy, bus.o_err_extra}); end
    bus.i_llr_ready = 1'b0;
  endtask

  task automatic test_sat;
    bus.i_llr_ready = 1'b1;
    start_user(2);
    strobe(32767, -32768, 1, -1, 256, 0);
    @(negedge tb_sclk);
    total++; if (bus.o_llr_valid !== 1'b1) begin bad++; $display("FAIL sat_valid got=%b want=1", bus.o_llr_valid); end
    total++; if (bus.o_llr_data !== pk(127, -128, 64, -64)) begin bad++; $display("FAIL sat_data got=%h want=%h", bus.o_llr_data, pk(127, -128, 64, -64)); end
    total++; if (bus.o_llr_last !== 1'b1) begin bad++; $display("FAIL sat_last got=%b want=1", bus.o_llr_last); end
    @(negedge tb_sclk);
    total++; if (bus.o_sat_cnt !== SAT_EXP) begin bad++; $display("FAIL sat_cnt got=%0d want=%0d", bus.o_sat_cnt, SAT_EXP); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL sat_busy got=%b want=0", bus.o_busy); end
  endtask

  task automatic test_odd;
    int n = 0;
    bus.i_llr_ready = 1'b1;
    start_user(113);
    total++; if (bus.o_err_extra !== 1'b0) begin bad++; $display("FAIL odd_err_pre got=%b want=0", bus.o_err_extra); end
    fork
      begin
        for (int k = 1; k <= 58; k++) strobe(k, k + 1, 2, 3, 4, 0);
      end
      begin
        repeat (70) begin
          @(negedge tb_sclk);
          if (bus.o_llr_valid) begin
            n++;
            total++; if (bus.o_llr_data !== pk(n, n + 1, (n == 57) ? 0 : 2, (n == 57) ? 0 : 3)) begin
              bad++; $display("FAIL odd_data[%0d] got=%h want=%h", n, bus.o_llr_data, pk(n, n + 1, (n == 57) ? 0 : 2, (n == 57) ? 0 : 3)); end
            total++; if (bus.o_llr_last !== (n == 57)) begin bad++; $display("FAIL odd_last[%0d] got=%b want=%b", n, bus.o_llr_last, (n == 57)); end
            total++; if (bus.o_llr_re1_vld !== (n != 57)) begin bad++; $display("FAIL odd_re1vld[%0d] got=%b want=%b", n, bus.o_llr_re1_vld, (n != 57)); end
          end
        end
      end
    join
    total++; if (n !== 57) begin bad++; $display("FAIL odd_count got=%0d want=57", n); end
    total++; if (bus.o_err_extra !== 1'b1) begin bad++; $display("FAIL odd_err_extra got=%b want=1", bus.o_err_extra); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL odd_busy got=%b want=0", bus.o_busy); end
  endtask

  task automatic test_full_rw;
    int n = 0;
    bus.i_llr_ready = 1'b0;
    start_user(100);
    for (int k = 11; k <= 14; k++) strobe(k, 0, 0, 0, 4, 0);
    @(negedge tb_sclk);
    strobe(15, 0, 0, 0, 4, 0);
    bus.i_llr_ready = 1'b1;
    repeat (8) begin
      @(negedge tb_sclk);
      if (bus.o_llr_valid) begin
        n++;
        total++; if (bus.o_llr_data !== pk(11 + n, 0, 0, 0)) begin bad++; $display("FAIL fullrw_data[%0d] got=%h want=%h", n, bus.o_llr_data, pk(11 + n, 0, 0, 0)); end
      end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL fullrw_count got=%0d want=4", n); end
    total++; if (bus.o_fifo_ovf !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b want=0", bus.o_fifo_ovf); end
  endtask

  task automatic test_backpressure;
    int n = 0;
    bus.i_llr_ready = 1'b0;
    start_user(100);
    for (int k = 1; k <= 6; k++) strobe(k, 0, 0, 0, 4, 0);
    @(negedge tb_sclk);
    total++; if (bus.o_fifo_ovf !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b want=1", bus.o_fifo_ovf); end
    bus.i_llr_ready = 1'b1;
    repeat (10) begin
      if (bus.o_llr_valid) begin
        n++;
        total++; if (bus.o_llr_data !== pk(n, 0, 0, 0)) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", n, bus.o_llr_data, pk(n, 0, 0, 0)); end
      end
      @(negedge tb_sclk);
    end
    total++; if (n !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", n); end
  endtask

  task automatic test_restart;
    int n = 0;
    bus.i_llr_ready = 1'b1;
    start_user(10);
    fork
      begin
        for (int k = 1; k <= 7; k++) strobe(k, 0, 0, 0, 4, k == 3);
      end
      begin
        repeat (12) begin
          @(negedge tb_sclk);
          if (bus.o_llr_valid) begin
            n++;
            total++; if (bus.o_llr_data !== pk(n, 0, 0, 0)) begin bad++; $display("FAIL rs_data[%0d] got=%h want=%h", n, bus.o_llr_data, pk(n, 0, 0, 0)); end
            total++; if (bus.o_llr_last !== (n == 7)) begin bad++; $display("FAIL rs_last[%0d] got=%b want=%b", n, bus.o_llr_last, (n == 7)); end
          end
        end
      end
    join
    total++; if (n !== 7) begin bad++; $display("FAIL rs_count got=%0d want=7", n); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rs_busy got=%b want=0", bus.o_busy); end
  endtask

  task automatic test_reset_mid;
    bus.i_llr_ready = 1'b0;
    start_user(10);
    for (int k = 1; k <= 3; k++) strobe(k, 0, 0, 0, 4, 0);
    @(negedge tb_sclk);
    total++; if (bus.o_llr_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b want=1", bus.o_llr_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if ({bus.o_llr_valid, bus.o_llr_last, bus.o_llr_re1_vld, bus.o_busy, bus.o_fifo_ovf, bus.o_err_extra} !== 6'b0) begin
      bad++; $display("FAIL rm_flags got=%b want=000000", {bus.o_llr_valid, bus.o_llr_last, bus.o_llr_re1_vld, bus.o_busy, bus.o_fifo_ovf, bus.o_err_extra}); end
    total++; if (bus.o_llr_data !== 32'h0) begin bad++; $display("FAIL rm_data got=%h want=0", bus.o_llr_data); end
    @(negedge tb_sclk);
    rst = 1'b0;
    bus.i_llr_ready = 1'b1;
    repeat (4) @(negedge tb_sclk);
    total++; if ({bus.o_llr_valid, bus.o_busy} !== 2'b00) begin bad++; $display("FAIL rm_after got=%b want=00", {bus.o_llr_valid, bus.o_busy}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_odd();
    test_full_rw();
    test_backpressure();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/slow_llr_calc.md
Name: slow_llr_calc

Overview:
- Downstream consumer of the slow PHY-to-LLR reader, which emits one RE pair (re0/re1 I/Q) plus a noise scale per o_data_strobe.
- Computes four scaled, rounded, saturated soft bits (LLRs) per strobe, one per I and Q of each RE, and tracks the RE count of the current user.
- Results are buffered in a small output FIFO for the LLR packer, which can back-pressure.

Parameters:
- LLR_W, 8, output LLR width (signed).
- SHIFT, 10, right shift applied to the product.
- FIFO_DEPTH, 4, output FIFO entries (power of 2).

Ports:
- i_core_clk  in  1  core clock
- i_rx_rst  in  1  asynchronous active-high reset
- i_user_start  in  1  pulse; latches i_cur_user_re_amounts and starts a new user
- i_cur_user_re_amounts  in  16  REs in the current user
- i_data_strobe  in  1  input pair valid, single cycle
- i_re0_data_i / i_re0_data_q / i_re1_data_i / i_re1_data_q  in  16 each  signed samples
- i_noise_data  in  16  unsigned inverse-noise scale
- i_llr_ready  in  1  downstream ready
- o_llr_valid  out  1  FIFO head valid
- o_llr_data  out  4*LLR_W  {re1_q, re1_i, re0_q, re0_i}
- o_llr_re1_vld  out  1  0 when the re1 slot is padding
- o_llr_last  out  1  last entry of the user
- o_busy  out  1  state RUN or pipeline non-empty
- o_fifo_ovf  out  1  sticky overflow flag
- o_err_extra  out  1  sticky flag: strobe received outside RUN
- o_sat_cnt  out  16  saturation count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters 0.
- FSM:
  - IDLE: i_user_start goes to RUN, or to DONE if the amount is 0 (no output produced).
  - RUN: each strobe adds 2 to re_cnt; a strobe with re_cnt+2 >= amount tags its entry last and goes to DONE.
  - DONE: returns to IDLE once the tagged entry leaves the FIFO.
  - i_user_start in any state restarts to RUN with re_cnt=0. Pipeline contents are kept. A strobe in the same cycle as start counts as the first pair of the new user.
- Odd amount: on the last pair, re1 is padding. Its LLR fields are forced to 0 and o_llr_re1_vld=0.
- Strobe outside RUN: ignored and sets o_err_extra. Cleared only by reset.
- Datapath, 2-cycle latency from strobe to FIFO write:
  - Stage 1: p = sample × {1'b0, noise}, 33-bit signed, for each of the 4 fields.
  - Stage 2: r = (p + 2^(SHIFT-1)) >>> SHIFT (arithmetic), then saturate to [-2^(LLR_W-1), 2^(LLR_W-1)-1].
- FIFO:
  - Write on stage-2 valid; read when o_llr_valid && i_llr_ready.
  - Simultaneous read and write when full is allowed (no overflow).
  - Write while full without a read: the entry is dropped and o_fifo_ovf is set (sticky).
  - o_llr_valid and o_llr_data are driven from the FIFO head with no combinational path from i_llr_ready.
- o_busy = (state==RUN) || stage1 valid || stage2 valid || FIFO non-empty.
- Reset mid-user: everything is cleared immediately (asynchronous); no partial entry emerges.

Optional Feature:
- SLOW_LLR_SAT_CNT_EN defined: o_sat_cnt counts saturated fields per written entry (0..4 added per cycle). It saturates at 0xFFFF and clears on i_user_start.
- Not defined: o_sat_cnt is tied to 0 and the counter logic is absent.

Test Plan:
- Basic: SHIFT=2, amount=4, two strobes with re0_i=12, re0_q=17, re1_i=34, re1_q=51, noise=6 → LLRs 18, 26 (102+2>>2), 51, 77 (306+2>>2); o_llr_last only on the 2nd entry, 2 cycles after its strobe; state back to IDLE after the read.
- Saturation: LLR_W=8, SHIFT=10, re0_i=0x7FFF, re0_q=0x8000, noise=0x0100 → 127 and -128 (0x80); with the macro, o_sat_cnt=2.
- Odd count: amount=113, 57 strobes → 57 entries; entry 57 has last=1, re1_vld=0 and re1 fields 0; a 58th strobe sets o_err_extra with no write.
- Back-pressure: i_llr_ready=0 while 6 strobes arrive with FIFO_DEPTH=4 → entries 1-4 held, 5 and 6 dropped, o_fifo_ovf=1; then ready=1 → exactly 4 entries read, in order.
- Full with read: FIFO full, ready=1 and a write in the same cycle → no overflow, count stays 4.
- Restart/reset: i_user_start at strobe 3 of amount=10 → re_cnt restarts, pipeline entries still emerge; i_rx_rst mid-user → all outputs 0 immediately.
